addr_map_cfg: RTL and testbench



---
 rtl/addr_map_cfg_pkg.sv | 8 +
 rtl/addr_map_rule_check.sv | 18 +
 rtl/addr_map_cfg.sv | 93 +++++++++
 tb/tb_addr_map_cfg.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_map_cfg_pkg.sv
// addr_map_cfg_pkg: shared types and helpers for the address-map configuration writer
package addr_map_cfg_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_COMMIT = 2'b01, OP_ABORT = 2'b10, OP_RSVD = 2'b11} cfg_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_RESP} state_e;
  function automatic int unsigned rule_width(input int unsigned addr_width);
    return 32 + 2 * addr_width;
  endfunction
endpackage

// File: rtl/addr_map_rule_check.sv
// addr_map_rule_check: combinational validator for a single {idx, start, end} rule
module addr_map_rule_check
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoIndices = 32'd2,
  parameter int unsigned AddrWidth = 32'd32,
  parameter bit          Napot     = 1'b0
) (
  input  logic [rule_width(AddrWidth)-1:0] rule_i,
  output logic                             ok_o
);
  logic [31:0]          idx;
  logic [AddrWidth-1:0] start_addr;
  logic [AddrWidth-1:0] end_addr;
  assign {idx, start_addr, end_addr} = rule_i;
  // an end address of zero means "up to the top of the address space"
  assign ok_o = (idx < NoIndices) && (Napot || (start_addr < end_addr) || (end_addr == '0));
endmodule

// File: rtl/addr_map_cfg.sv
// addr_map_cfg: shadow/active rule table writer with sequential commit validation
module addr_map_cfg
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoIndices    = 32'd2,
  parameter int unsigned NoRules      = 32'd4,
  parameter int unsigned AddrWidth    = 32'd32,
  parameter bit          Napot        = 1'b0,
  parameter int unsigned RuleWidth    = rule_width(AddrWidth),
  parameter int unsigned RuleIdxWidth = NoRules > 1 ? $clog2(NoRules) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [1:0]                   cfg_op_i,
  input  logic [RuleIdxWidth-1:0]      cfg_rule_i,
  input  logic [RuleWidth-1:0]         cfg_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_error_o,
  output logic [RuleIdxWidth-1:0]      rsp_bad_rule_o,
  output logic [NoRules*RuleWidth-1:0] addr_map_o,
  output logic                         map_valid_o,
  output logic                         config_ongoing_o
);
  state_e                             state, state_n;
  cfg_op_e                            op;
  logic [RuleIdxWidth-1:0]            cnt, bad_n;
  logic [NoRules-1:0][RuleWidth-1:0]  shadow, active;
  logic                               map_valid, err_n, ok, hs, in_range, last;
  assign op               = cfg_op_e'(cfg_op_i);
  assign cfg_ready_o      = state == S_IDLE;
  assign rsp_valid_o      = state == S_RESP;
  assign hs               = cfg_valid_i & cfg_ready_o;
  assign in_range         = 32'(cfg_rule_i) < NoRules;
  assign last             = cnt == RuleIdxWidth'(NoRules - 1);
  assign addr_map_o       = active;
  assign map_valid_o      = map_valid;
  assign config_ongoing_o = ~map_valid | (state == S_CHECK) | (state == S_COMMIT);
  addr_map_rule_check #(
    .NoIndices(NoIndices),
    .AddrWidth(AddrWidth),
    .Napot    (Napot)
  ) u_check (
    .rule_i(shadow[cnt]),
    .ok_o  (ok)
  );
  // next state and the response fields latched on entry to RESP
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    bad_n   = '0;
    case (state)
      S_IDLE: if (hs) begin
        state_n = op == OP_COMMIT ? S_CHECK : S_RESP;
        err_n   = (op == OP_RSVD) || (op == OP_WRITE && !in_range);
      end
      S_CHECK: begin
        state_n = !ok ? S_RESP : last ? S_COMMIT : S_CHECK;
        err_n   = !ok;
        bad_n   = ok ? '0 : cnt;
      end
      S_COMMIT: state_n = S_RESP;
      default:  state_n = rsp_ready_i ? S_IDLE : S_RESP;
    endcase
  end
  // state register, table updates and held response fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      shadow         <= '0;
      active         <= '0;
      map_valid      <= 1'b0;
      rsp_error_o    <= 1'b0;
      rsp_bad_rule_o <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == S_CHECK ? cnt + 1'b1 : '0;
      if (hs && op == OP_WRITE && in_range) shadow[cfg_rule_i] <= cfg_data_i;
      if (hs && op == OP_ABORT) shadow <= active;
      if (state == S_COMMIT) begin
        active    <= shadow;
        map_valid <= 1'b1;
      end
      if (state != S_RESP && state_n == S_RESP) begin
        rsp_error_o    <= err_n;
        rsp_bad_rule_o <= bad_n;
      end
    end
  end
endmodule

// File: tb/tb_addr_map_cfg.sv
// tb_addr_map_cfg: scoreboard bench for addr_map_cfg with a range and a napot instance
module tb_addr_map_cfg;
  localparam int NR = 4;
  localparam int RW = 96;
  localparam int MW = NR * RW;
  typedef struct {
    int          b;
    logic [1:0]  op;
    logic [1:0]  rule;
    logic [RW-1:0] data;
  } cmd_t;
  typedef struct {
    logic          err;
    logic [1:0]    bad;
    int            lat;
    logic [MW-1:0] map;
    logic          ong;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0]    valid, ready, rsp_valid, rsp_ready, rsp_err, mvalid, ongoing;
  logic [1:0]    op [2];
  logic [1:0]    rule [2];
  logic [RW-1:0] data [2];
  logic [1:0]    badr [2];
  logic [MW-1:0] amap [2];
  logic [RW-1:0] sh [2][NR];
  logic [RW-1:0] ac [2][NR];
  logic          mv [2];
  exp_t          sbq[$];
  int            total = 0;
  int            bad_cnt = 0;
  addr_map_cfg #(.NoIndices(3), .NoRules(NR), .AddrWidth(32), .Napot(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(valid[0]), .cfg_ready_o(ready[0]),
    .cfg_op_i(op[0]), .cfg_rule_i(rule[0]), .cfg_data_i(data[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_error_o(rsp_err[0]),
    .rsp_bad_rule_o(badr[0]), .addr_map_o(amap[0]), .map_valid_o(mvalid[0]),
    .config_ongoing_o(ongoing[0])
  );
  addr_map_cfg #(.NoIndices(3), .NoRules(NR), .AddrWidth(32), .Napot(1'b1)) dut_n (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(valid[1]), .cfg_ready_o(ready[1]),
    .cfg_op_i(op[1]), .cfg_rule_i(rule[1]), .cfg_data_i(data[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_error_o(rsp_err[1]),
    .rsp_bad_rule_o(badr[1]), .addr_map_o(amap[1]), .map_valid_o(mvalid[1]),
    .config_ongoing_o(ongoing[1])
  );
  function automatic logic [RW-1:0] mk(input logic [31:0] i, input logic [31:0] s, input logic [31:0] e);
    return {i, s, e};
  endfunction
  function automatic logic rule_ok(input int b, input logic [RW-1:0] r);
    return (r[95:64] < 3) && (b == 1 || r[63:32] < r[31:0] || r[31:0] == 0);
  endfunction
  function automatic logic [MW-1:0] act_map(input int b);
    return {ac[b][3], ac[b][2], ac[b][1], ac[b][0]};
  endfunction
  task automatic clear_model(input int b);
    for (int i = 0; i < NR; i++) begin
      sh[b][i] = '0;
      ac[b][i] = '0;
    end
    mv[b] = 1'b0;
  endtask
  task automatic predict(input cmd_t c, output exp_t e);
    e.err = 1'b0;
    e.bad = 2'd0;
    e.lat = 1;
    case (c.op)
      2'b00: sh[c.b][c.rule] = c.data;
      2'b01: begin
        e.lat = NR + 2;
        for (int i = NR - 1; i >= 0; i--)
          if (!rule_ok(c.b, sh[c.b][i])) begin
            e.err = 1'b1;
            e.bad = 2'(i);
            e.lat = i + 2;
          end
        if (!e.err) begin
          for (int i = 0; i < NR; i++) ac[c.b][i] = sh[c.b][i];
          mv[c.b] = 1'b1;
        end
      end
      2'b10: for (int i = 0; i < NR; i++) sh[c.b][i] = ac[c.b][i];
      default: e.err = 1'b1;
    endcase
    e.map = act_map(c.b);
    e.ong = !mv[c.b];
  endtask
  task automatic do_cmd(input cmd_t c, output logic err, output logic [1:0] bd, output int lat,
                        output logic [MW-1:0] mp, output logic ong, output logic rdy);
    valid[c.b] = 1'b1;
    op[c.b]    = c.op;
    rule[c.b]  = c.rule;
    data[c.b]  = c.data;
    @(posedge clk); #1;
    valid[c.b] = 1'b0;
    lat = 1;
    rdy = 1'b0;
    while (!rsp_valid[c.b] && lat < 50) begin
      rdy |= ready[c.b];
      @(posedge clk); #1;
      lat++;
    end
    err = rsp_err[c.b];
    bd  = badr[c.b];
    mp  = amap[c.b];
    ong = ongoing[c.b];
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) begin
      total++;
      if (amap[b] !== '0 || mvalid[b] !== 1'b0 || ongoing[b] !== 1'b1 || ready[b] !== 1'b1 ||
          rsp_valid[b] !== 1'b0 || rsp_err[b] !== 1'b0 || badr[b] !== 2'd0) begin
        bad_cnt++;
        $display("FAIL reset[%0d]: map_nz=%0b mv=%0b ong=%0b rdy=%0b rv=%0b err=%0b bad=%0d, want 0 0 1 1 0 0 0",
                 b, amap[b] != '0, mvalid[b], ongoing[b], ready[b], rsp_valid[b], rsp_err[b], badr[b]);
      end
      clear_model(b);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_good_commit();
    cmd_t c[$];
    exp_t e;
    logic err, ong, rdy;
    logic [1:0] bd;
    logic [MW-1:0] mp;
    int lat;
    c.push_back('{0, 2'b00, 2'd0, mk(0, 32'h0, 32'h1000)});
    c.push_back('{0, 2'b00, 2'd1, mk(1, 32'h1000, 32'h2000)});
    c.push_back('{0, 2'b00, 2'd2, mk(2, 32'h2000, 32'h3000)});
    c.push_back('{0, 2'b00, 2'd3, mk(2, 32'h8000, 32'h0)});
    c.push_back('{0, 2'b01, 2'd0, '0});
    foreach (c[i]) begin
      predict(c[i], e);
      sbq.push_back(e);
      do_cmd(c[i], err, bd, lat, mp, ong, rdy);
      e = sbq.pop_front();
      total++;
      if (err !== e.err || bd !== e.bad || lat != e.lat || mp !== e.map || ong !== e.ong || rdy !== 1'b0) begin
        bad_cnt++;
        $display("FAIL good_commit[%0d]: err=%0b bad=%0d lat=%0d ong=%0b rdy=%0b map=%h, want err=%0b bad=%0d lat=%0d ong=%0b rdy=0 map=%h",
                 i, err, bd, lat, ong, rdy, mp, e.err, e.bad, e.lat, e.ong, e.map);
      end
    end
  endtask
  task automatic test_start_end();
    cmd_t c[$];
    exp_t e;
    logic err, ong, rdy;
    logic [1:0] bd;
    logic [MW-1:0] mp;
    int lat;
    c.push_back('{0, 2'b00, 2'd2, mk(2, 32'h3000, 32'h2000)});
    c.push_back('{0, 2'b01, 2'd0, '0});
    foreach (c[i]) begin
      predict(c[i], e);
      sbq.push_back(e);
      do_cmd(c[i], err, bd, lat, mp, ong, rdy);
      e = sbq.pop_front();
      total++;
      if (err !== e.err || bd !== e.bad || lat != e.lat || mp !== e.map || ong !== e.ong || rdy !== 1'b0) begin
        bad_cnt++;
        $display("FAIL start_end[%0d]: err=%0b bad=%0d lat=%0d ong=%0b rdy=%0b map=%h, want err=%0b bad=%0d lat=%0d ong=%0b rdy=0 map=%h",
                 i, err, bd, lat, ong, rdy, mp, e.err, e.bad, e.lat, e.ong, e.map);
      end
    end
  endtask
  task automatic test_bad_idx();
    cmd_t c[$];
    exp_t e;
    logic err, ong, rdy;
    logic [1:0] bd;
    logic [MW-1:0] mp;
    int lat;
    c.push_back('{0, 2'b00, 2'd1, mk(3, 32'h1000, 32'h2000)});
    c.push_back('{0, 2'b01, 2'd0, '0});
    c.push_back('{0, 2'b10, 2'd0, '0});
    c.push_back('{0, 2'b01, 2'd0, '0});
    c.push_back('{0, 2'b11, 2'd0, '0});
    foreach (c[i]) begin
      predict(c[i], e);
      sbq.push_back(e);
      do_cmd(c[i], err, bd, lat, mp, ong, rdy);
      e = sbq.pop_front();
      total++;
      if (err !== e.err || bd !== e.bad || lat != e.lat || mp !== e.map || ong !== e.ong || rdy !== 1'b0) begin
        bad_cnt++;
        $display("FAIL bad_idx[%0d]: err=%0b bad=%0d lat=%0d ong=%0b rdy=%0b map=%h, want err=%0b bad=%0d lat=%0d ong=%0b rdy=0 map=%h",
                 i, err, bd, lat, ong, rdy, mp, e.err, e.bad, e.lat, e.ong, e.map);
      end
    end
  endtask
  task automatic test_backpressure();
    cmd_t c;
    exp_t e;
    int lat;
    c = '{0, 2'b11, 2'd0, '0};
    predict(c, e);
    sbq.push_back(e);
    rsp_ready[0] = 1'b0;
    valid[0] = 1'b1;
    op[0] = 2'b11;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    lat = 1;
    while (!rsp_valid[0] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sbq.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== e.err || badr[0] !== e.bad || ready[0] !== 1'b0 || lat != e.lat) begin
        bad_cnt++;
        $display("FAIL backpressure[%0d]: rv=%0b err=%0b bad=%0d rdy=%0b lat=%0d, want rv=1 err=%0b bad=%0d rdy=0 lat=%0d",
                 k, rsp_valid[0], rsp_err[0], badr[0], ready[0], lat, e.err, e.bad, e.lat);
      end
      valid[0] = 1'b1;
      op[0]    = 2'b00;
      rule[0]  = 2'd0;
      data[0]  = mk(7, 5, 1);
      @(posedge clk); #1;
    end
    valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      bad_cnt++;
      $display("FAIL backpressure_release: rdy=%0b rv=%0b, want rdy=1 rv=0", ready[0], rsp_valid[0]);
    end
  endtask
  task automatic test_napot();
    cmd_t c[$];
    exp_t e;
    logic err, ong, rdy;
    logic [1:0] bd;
    logic [MW-1:0] mp;
    int lat;
    c.push_back('{0, 2'b01, 2'd0, '0});
    c.push_back('{1, 2'b00, 2'd0, mk(1, 32'h1000, 32'hF000)});
    c.push_back('{1, 2'b00, 2'd3, mk(1, 32'h1000, 32'h0F00)});
    c.push_back('{1, 2'b01, 2'd0, '0});
    c.push_back('{0, 2'b00, 2'd3, mk(1, 32'h1000, 32'h0F00)});
    c.push_back('{0, 2'b01, 2'd0, '0});
    foreach (c[i]) begin
      predict(c[i], e);
      sbq.push_back(e);
      do_cmd(c[i], err, bd, lat, mp, ong, rdy);
      e = sbq.pop_front();
      total++;
      if (err !== e.err || bd !== e.bad || lat != e.lat || mp !== e.map || ong !== e.ong || rdy !== 1'b0) begin
        bad_cnt++;
        $display("FAIL napot[%0d]: err=%0b bad=%0d lat=%0d ong=%0b rdy=%0b map=%h, want err=%0b bad=%0d lat=%0d ong=%0b rdy=0 map=%h",
                 i, err, bd, lat, ong, rdy, mp, e.err, e.bad, e.lat, e.ong, e.map);
      end
    end
  endtask
  task automatic test_reset_mid();
    cmd_t c;
    exp_t e;
    logic err, ong, rdy;
    logic [1:0] bd;
    logic [MW-1:0] mp;
    int lat;
    valid[0] = 1'b1;
    op[0] = 2'b01;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model(0);
    total++;
    if (ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || amap[0] !== '0 || mvalid[0] !== 1'b0 || ongoing[0] !== 1'b1) begin
      bad_cnt++;
      $display("FAIL reset_mid: rdy=%0b rv=%0b map_nz=%0b mv=%0b ong=%0b, want 1 0 0 0 1",
               ready[0], rsp_valid[0], amap[0] != '0, mvalid[0], ongoing[0]);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (rsp_valid[0] !== 1'b0) begin
        bad_cnt++;
        $display("FAIL reset_mid_norsp[%0d]: rv=%0b, want 0", k, rsp_valid[0]);
      end
      @(posedge clk); #1;
    end
    c = '{0, 2'b01, 2'd0, '0};
    predict(c, e);
    sbq.push_back(e);
    do_cmd(c, err, bd, lat, mp, ong, rdy);
    e = sbq.pop_front();
    total++;
    if (err !== e.err || bd !== e.bad || lat != e.lat || mp !== e.map || ong !== e.ong || rdy !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_mid_commit: err=%0b bad=%0d lat=%0d ong=%0b rdy=%0b map=%h, want err=%0b bad=%0d lat=%0d ong=%0b rdy=0 map=%h",
               err, bd, lat, ong, rdy, mp, e.err, e.bad, e.lat, e.ong, e.map);
    end
  endtask
  initial begin
    valid = '0;
    rsp_ready = 2'b11;
    for (int b = 0; b < 2; b++) begin
      op[b]   = 2'b00;
      rule[b] = 2'd0;
      data[b] = '0;
    end
    test_reset();
    test_good_commit();
    test_start_end();
    test_bad_idx();
    test_backpressure();
    test_napot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end
endmodule
